// File: rtl/piffla_pkg.sv
// Shared definitions for the PIF multi-channel LED flasher.
package piffla_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

endpackage

// File: rtl/piffla_down_counter.sv
// Reloading down-counter; at_zero is a registered flag that is high while the count sits at 0.
module piffla_down_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RELOAD = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic at_zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Decrement on enable, reload once the zero state has been consumed
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (cnt_q == '0) begin
                cnt_d = WIDTH'(RELOAD);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= WIDTH'(RELOAD);
            at_zero <= (RELOAD == 0);
        end else begin
            cnt_q   <= cnt_d;
            at_zero <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/pif_flasher_mc.sv
// Multi-channel LED flasher: per-channel OFF/ON/BLINK/BREATHE driven from a shared
// prescaled tick, blink timebase and free-running PWM counter.
module pif_flasher_mc
    import piffla_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned PWM_W       = 8,
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned BLINK_TICKS = 256,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              xclk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    output logic [N_CH-1:0]   led,
    output logic              tick
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PWM_W-1:0] LVL_MAX = '1;

    logic             blk_zero;
    logic             blink_wrap;
    logic             blink_phase;
    logic [PWM_W-1:0] pwm_ctr;
    logic             wr_valid;

    // Prescaler: tick is high during the cycle its count sits at zero
    piffla_down_counter #(
        .WIDTH  (PRE_W),
        .RELOAD (PRESCALE - 1)
    ) u_prescale (
        .clk     (xclk),
        .rst_n   (sys_rst),
        .en      (1'b1),
        .at_zero (tick)
    );

    // Blink timebase counts ticks; phase flips on the BLINK_TICKS-th tick
    piffla_down_counter #(
        .WIDTH  (BLK_W),
        .RELOAD (BLINK_TICKS - 1)
    ) u_blink (
        .clk     (xclk),
        .rst_n   (sys_rst),
        .en      (tick),
        .at_zero (blk_zero)
    );

    assign blink_wrap = tick & blk_zero;
    assign wr_valid   = cfg_we && (32'(cfg_ch) < N_CH);

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            pwm_ctr     <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_ctr <= pwm_ctr + 1'b1;
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mode_e            mode_q;
        mode_e            mode_d;
        logic [PWM_W-1:0] level_q;
        logic [PWM_W-1:0] level_d;
        logic             dir_q;
        logic             dir_d;
        logic             led_q;
        logic             led_d;
        logic             hit;

        assign hit    = wr_valid && (cfg_ch == CH_W'(i));
        assign led[i] = led_q;

        // LED decode from current mode; a config write overrides any ramp step on the same edge
        always_comb begin
            mode_d  = mode_q;
            level_d = level_q;
            dir_d   = dir_q;
            led_d   = 1'b0;

            unique case (mode_q)
                MODE_OFF:     led_d = 1'b0;
                MODE_ON:      led_d = 1'b1;
                MODE_BLINK:   led_d = blink_phase ^ 1'(i % 2);
                MODE_BREATHE: led_d = (pwm_ctr < level_q);
                default:      led_d = 1'b0;
            endcase

            if (hit) begin
                mode_d  = mode_e'(cfg_mode);
                level_d = '0;
                dir_d   = 1'b0;
            end else if (tick && (mode_q == MODE_BREATHE)) begin
                if (!dir_q) begin
                    if (level_q == LVL_MAX) begin
                        dir_d   = 1'b1;
                        level_d = PWM_W'(LVL_MAX - 1'b1);
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end else begin
                    if (level_q == '0) begin
                        dir_d   = 1'b0;
                        level_d = PWM_W'(1);
                    end else begin
                        level_d = level_q - 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge xclk or negedge sys_rst) begin
            if (!sys_rst) begin
                mode_q  <= MODE_OFF;
                level_q <= '0;
                dir_q   <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                level_q <= level_d;
                dir_q   <= dir_d;
                led_q   <= led_d;
            end
        end
    end

endmodule

// File: tb/tb_pif_flasher_mc.sv
// Directed bench for pif_flasher_mc with a short prescaler, 3-bit PWM and 3 channels.
module tb_pif_flasher_mc;
    import piffla_pkg::*;

    localparam int unsigned N_CH        = 3;
    localparam int unsigned PWM_W       = 3;
    localparam int unsigned PRESCALE    = 4;
    localparam int unsigned BLINK_TICKS = 2;
    localparam int unsigned CH_W        = 2;

    logic              xclk     = 1'b0;
    logic              sys_rst  = 1'b0;
    logic              cfg_we   = 1'b0;
    logic [CH_W-1:0]   cfg_ch   = '0;
    logic [MODE_W-1:0] cfg_mode = '0;
    logic [N_CH-1:0]   led;
    logic              tick;

    int total = 0;
    int bad   = 0;
    int e     = 0;   // rising edges since the last reset release
    int cur   = 0;   // expected ch1 breathe level
    int k     = 0;
    logic [N_CH-1:0] exp_led;

    int lv_exp [19] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};
    int dr_exp [19] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    always #5 xclk = ~xclk;

    pif_flasher_mc #(
        .N_CH        (N_CH),
        .PWM_W       (PWM_W),
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .xclk     (xclk),
        .sys_rst  (sys_rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .led      (led),
        .tick     (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic edge1();
        @(negedge xclk);
        e++;
    endtask

    task automatic wr(input logic [CH_W-1:0] ch, input logic [MODE_W-1:0] m);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = m;
        edge1();
        cfg_we   = 1'b0;
    endtask

    // blink_phase as seen by the led register at edge ev (phase flips at edges 8, 16, ...)
    function automatic logic ph(input int ev);
        return (((ev - 1) / 8) % 2) == 1;
    endfunction

    function automatic int pwmv(input int ev);
        return (ev - 1) % 8;
    endfunction

    initial begin
        repeat (3) @(negedge xclk);
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));

        sys_rst = 1'b1;
        e = 0;
        for (int n = 1; n <= 12; n++) begin
            edge1();
            chk("tick_seq", 32'(tick), 32'(e % 4 == 3));
        end
        chk("led_idle", 32'(led), 32'(0));

        wr(2'd0, MODE_ON);
        chk("on_lat0", 32'(led), 32'(0));
        edge1();
        chk("on_lat1", 32'(led), 32'(3'b001));

        wr(2'd3, MODE_OFF);
        wr(2'd3, MODE_ON);
        edge1();
        edge1();
        chk("oor_ignored", 32'(led), 32'(3'b001));

        wr(2'd0, MODE_BLINK);
        wr(2'd1, MODE_BLINK);
        for (int n = 0; n < 24; n++) begin
            edge1();
            exp_led = {1'b0, ~ph(e), ph(e)};
            chk("blink", 32'(led), 32'(exp_led));
        end

        wr(2'd1, MODE_BREATHE);
        cur = 0;
        k = 0;
        while (k < 19) begin
            edge1();
            exp_led = {1'b0, pwmv(e) < cur, ph(e)};
            chk("breathe_led", 32'(led), 32'(exp_led));
            if (e % 4 == 0) begin
                cur = lv_exp[k];
                chk("level", 32'(dut.g_ch[1].level_q), 32'(cur));
                chk("dir", 32'(dut.g_ch[1].dir_q), 32'(dr_exp[k]));
                k++;
            end
        end

        // Rewrite ch1 on the edge that would ramp level 5 -> 6
        while ((e + 1) % 4 != 0) begin
            edge1();
            exp_led = {1'b0, pwmv(e) < cur, ph(e)};
            chk("pre_coll_led", 32'(led), 32'(exp_led));
        end
        chk("coll_tick", 32'(tick), 32'(1));
        chk("coll_level_before", 32'(dut.g_ch[1].level_q), 32'(5));
        wr(2'd1, MODE_BREATHE);
        exp_led = {1'b0, pwmv(e) < cur, ph(e)};
        chk("coll_led", 32'(led), 32'(exp_led));
        chk("coll_level", 32'(dut.g_ch[1].level_q), 32'(0));
        chk("coll_dir", 32'(dut.g_ch[1].dir_q), 32'(0));
        cur = 0;
        for (int n = 0; n < 3; n++) begin
            edge1();
            exp_led = {1'b0, 1'b0, ph(e)};
            chk("post_coll_led", 32'(led), 32'(exp_led));
        end

        wr(2'd2, MODE_ON);
        edge1();
        chk("ch2_on", 32'(led[2]), 32'(1));

        @(posedge xclk);
        #2 sys_rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'(0));
        chk("async_rst_tick", 32'(tick), 32'(0));
        chk("async_rst_level", 32'(dut.g_ch[1].level_q), 32'(0));
        repeat (2) @(negedge xclk);
        sys_rst = 1'b1;
        e = 0;
        for (int n = 1; n <= 12; n++) begin
            edge1();
            chk("tick_seq2", 32'(tick), 32'(e % 4 == 3));
        end
        chk("led_after_rst", 32'(led), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
